// File: rtl/img_pkg.sv
`default_nettype none
// =============================================================================
// Package : img_pkg
// Brief   : Shared image geometry, read threshold, FSM encoding and buffer-select
//           helpers for the row buffer sequencer.
// Rev     : 1.0  initial release
// =============================================================================
package img_pkg;

    localparam int IMG_W      = 512;
    localparam int PIX_W      = 8;
    localparam int NUM_BUF    = 4;
    localparam int ROW_THRESH = 3 * IMG_W;

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_RD_ROW = 1'b1;

    function automatic logic [NUM_BUF-1:0] sel_onehot(input logic [1:0] sel);
        return {{(NUM_BUF-1){1'b0}}, 1'b1} << sel;
    endfunction

    // Three consecutive buffers starting at sel, wrapping 3 -> 0.
    function automatic logic [NUM_BUF-1:0] sel_window(input logic [1:0] sel);
        return sel_onehot(sel) | sel_onehot(sel + 2'd1) | sel_onehot(sel + 2'd2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_sel_mux.sv
`default_nettype none
// =============================================================================
// Module : row_sel_mux
// Brief  : Rotates the four 3-pixel buffer outputs into a 3x3 window, with
//          buffer i_sel as the top row.
// Rev    : 1.0  initial release
// =============================================================================
module row_sel_mux
    import img_pkg::*;
(
    input  logic [1:0]                 i_sel,
    input  logic [NUM_BUF*3*PIX_W-1:0] i_buf_data,
    output logic [9*PIX_W-1:0]         o_window
);

    localparam int c_ROW_BITS = 3 * PIX_W;

    genvar r;
    generate
        for (r = 0; r < 3; r++) begin : g_row
            logic [1:0] w_idx;
            assign w_idx = i_sel + 2'(r);
            // Row 0 (top) lands in the most significant slice.
            assign o_window[(2-r)*c_ROW_BITS +: c_ROW_BITS] =
                i_buf_data[w_idx*c_ROW_BITS +: c_ROW_BITS];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/row_buffer_ctrl.sv
`default_nettype none
// =============================================================================
// Module : row_buffer_ctrl
// Brief  : Round-robin writer and lock-step 3-row reader for four RowBuffers,
//          producing one 3x3 window per clock while a row is being read.
// Rev    : 1.0  initial release
// =============================================================================
module row_buffer_ctrl
    import img_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_pixel_valid,
    input  logic [PIX_W-1:0]           i_pixel,
    output logic                       o_ready,
    output logic [NUM_BUF-1:0]         o_buf_wr_en,
    output logic [PIX_W-1:0]           o_buf_wr_data,
    output logic [NUM_BUF-1:0]         o_buf_rd_en,
    input  logic [NUM_BUF*3*PIX_W-1:0] i_buf_data,
    output logic [9*PIX_W-1:0]         o_window,
    output logic                       o_window_valid,
    output logic                       o_intr
);

    localparam int c_FILL_W = $clog2(NUM_BUF*IMG_W + 1);
    localparam int c_CNT_W  = $clog2(IMG_W);

    localparam logic [c_FILL_W-1:0] c_FILL_MAX    = c_FILL_W'(NUM_BUF*IMG_W);
    localparam logic [c_FILL_W-1:0] c_FILL_THRESH = c_FILL_W'(ROW_THRESH);
    localparam logic [c_FILL_W-1:0] c_FILL_ROW    = c_FILL_W'(IMG_W);
    localparam logic [c_FILL_W-1:0] c_FILL_ONE    = c_FILL_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST    = c_CNT_W'(IMG_W-1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE     = c_CNT_W'(1);

    logic [1:0]          r_wr_sel;
    logic [1:0]          r_rd_sel;
    logic [c_CNT_W-1:0]  r_wr_cnt;
    logic [c_CNT_W-1:0]  r_rd_cnt;
    logic [c_FILL_W-1:0] r_fill;
    logic [0:0]          r_state;
    logic [9*PIX_W-1:0]  r_window;
    logic                r_window_valid;
    logic                r_intr;

    logic                w_accept;
    logic                w_reading;
    logic                w_rd_last;
    logic [9*PIX_W-1:0]  w_window;

    assign o_ready        = (r_fill != c_FILL_MAX);
    assign w_accept       = i_pixel_valid & o_ready;
    assign o_buf_wr_en    = sel_onehot(r_wr_sel) & {NUM_BUF{w_accept}};
    assign o_buf_wr_data  = i_pixel;

    assign w_reading      = (r_state == c_ST_RD_ROW);
    assign w_rd_last      = w_reading && (r_rd_cnt == c_CNT_LAST);
    assign o_buf_rd_en    = w_reading ? sel_window(r_rd_sel) : '0;

    assign o_window       = r_window;
    assign o_window_valid = r_window_valid;
    assign o_intr         = r_intr;

    row_sel_mux u_row_sel_mux (
        .i_sel      (r_rd_sel),
        .i_buf_data (i_buf_data),
        .o_window   (w_window)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt <= '0;
            r_wr_sel <= '0;
        end else if (w_accept) begin
            if (r_wr_cnt == c_CNT_LAST) begin
                r_wr_cnt <= '0;
                r_wr_sel <= r_wr_sel + 2'd1;
            end else begin
                r_wr_cnt <= r_wr_cnt + c_CNT_ONE;
            end
        end
    end

    // Stored-pixel count: one in per accept, a whole row out per completed read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill <= '0;
        end else begin
            case ({w_accept, w_rd_last})
                2'b10:   r_fill <= r_fill + c_FILL_ONE;
                2'b01:   r_fill <= r_fill - c_FILL_ROW;
                2'b11:   r_fill <= r_fill + c_FILL_ONE - c_FILL_ROW;
                default: r_fill <= r_fill;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_rd_sel       <= '0;
            r_rd_cnt       <= '0;
            r_window       <= '0;
            r_window_valid <= 1'b0;
            r_intr         <= 1'b0;
        end else begin
            r_window_valid <= w_reading;
            r_intr         <= w_rd_last;
            if (w_reading) begin
                r_window <= w_window;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (r_fill >= c_FILL_THRESH) begin
                        r_state <= c_ST_RD_ROW;
                    end
                end
                c_ST_RD_ROW: begin
                    if (r_rd_cnt == c_CNT_LAST) begin
                        r_rd_cnt <= '0;
                        r_rd_sel <= r_rd_sel + 2'd1;
                        r_state  <= c_ST_IDLE;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + c_CNT_ONE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
